// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: req/ack instruction-memory port between fetch and imem.
// master = fetch stage, slave = memory.
interface if_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: owns the PC, fetches over a req/ack port into IF/ID.
// Optional IF_PERF_CNT_EN adds fetch_cnt / bubble_cnt outputs.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic [31:0]      branch_addr,
    if_fetch_stage_if.master imem,
    output logic [31:0]      PC_out,
    output logic [31:0]      instruction,
    output logic             valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DROP
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] buf_word;
    logic [31:0] buf_pc;
    logic        buf_valid;
    logic        req_c;
    logic        acc;
    logic        take;
    logic        pend;

    always_comb begin
        req_c = 1'b0;
        case (state)
            FETCH:   req_c = 1'b1;
            DROP:    req_c = 1'b1;
            HOLD:    req_c = !freeze && !branch_taken;
            default: req_c = 1'b0;
        endcase
    end

    assign imem.req  = rst && req_c;
    assign imem.addr = pc;
    assign acc       = imem.req && imem.ack;
    assign take      = acc && (state != DROP);
    assign pend      = imem.req && !imem.ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            tgt         <= '0;
            buf_word    <= '0;
            buf_pc      <= '0;
            buf_valid   <= 1'b0;
            PC_out      <= '0;
            instruction <= BUBBLE;
            valid       <= 1'b0;
`ifdef IF_PERF_CNT_EN
            fetch_cnt   <= '0;
            bubble_cnt  <= '0;
`endif
        end else begin
            if (branch_taken) begin
                valid       <= 1'b0;
                instruction <= BUBBLE;
                buf_valid   <= 1'b0;
                // an un-acked request cannot be aborted: finish it, then redirect
                if (pend) begin
                    tgt   <= branch_addr;
                    state <= DROP;
                end else begin
                    pc    <= branch_addr;
                    state <= FETCH;
                end
            end else begin
                if (state == DROP) begin
                    if (imem.ack) begin
                        pc    <= tgt;
                        state <= FETCH;
                    end
                end else if (acc) begin
                    pc <= pc + 32'd4;
                end

                if (freeze) begin
                    if (take) begin
                        buf_word  <= imem.rdata;
                        buf_pc    <= pc + 32'd4;
                        buf_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end else if (buf_valid) begin
                    valid       <= 1'b1;
                    instruction <= buf_word;
                    PC_out      <= buf_pc;
                    // the drain cycle also fetches; a same-cycle ack refills
                    if (take) begin
                        buf_word <= imem.rdata;
                        buf_pc   <= pc + 32'd4;
                    end else begin
                        buf_valid <= 1'b0;
                        state     <= FETCH;
                    end
                end else if (take) begin
                    valid       <= 1'b1;
                    instruction <= imem.rdata;
                    PC_out      <= pc + 32'd4;
                end else begin
                    valid       <= 1'b0;
                    instruction <= BUBBLE;
                end
            end
`ifdef IF_PERF_CNT_EN
            if (take && !branch_taken)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (!freeze && (branch_taken || (!buf_valid && !take)))
                bubble_cnt <= bubble_cnt + 32'd1;
`endif
        end
    end

endmodule
